// File: rtl/axi_clint_if.sv
// AXI4 channel bundle between the crossbar CLINT port (master) and the timer responder (slave).
interface axi_clint_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );
endinterface

// File: rtl/axi_clint_responder.sv
// CLINT mtime responder: free-running 64-bit timer behind a minimal AXI4 slave.
// Reads of the low word snapshot the full counter so the high word read is tear-free.
module axi_clint_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned DIV       = 1
) (
  input logic         clk,
  input logic         rst_n,
  axi_clint_if.slave  bus
);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic { R_IDLE, R_DATA } rstate_e;
  typedef enum logic { W_IDLE, W_RESP } wstate_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   snap_q, snap_d;

  rstate_e       rstate_q, rstate_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [3:0]    rid_q, rid_d;
  logic          rlast_q, rlast_d;
  logic [7:0]    beats_q, beats_d;

  wstate_e       wstate_q, wstate_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic          aw_legal_q, aw_legal_d;
  logic          aw_hi_q, aw_hi_d;
  logic [3:0]    aw_id_q, aw_id_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [3:0]    bid_q, bid_d;

  logic          inc;
  logic          ar_legal, aw_legal_now;
  logic          aw_hs, w_hs, commit;
  logic          eff_legal, eff_hi;
  logic [3:0]    eff_id;
  logic [31:0]   eff_wdata;
  logic [3:0]    eff_wstrb;
  logic [31:0]   word;

  assign inc = (presc_q == PW'(DIV - 1));

  assign ar_legal = (bus.arsize == 3'b010) && (bus.arlen == 8'd0) && (bus.arburst == 2'b01) &&
                    ((bus.araddr == BASE_ADDR) || (bus.araddr == BASE_ADDR + 32'd4));
  assign aw_legal_now = (bus.awsize == 3'b010) && (bus.awlen == 8'd0) && (bus.awburst == 2'b01) &&
                        ((bus.awaddr == BASE_ADDR) || (bus.awaddr == BASE_ADDR + 32'd4));

  assign aw_hs = (wstate_q == W_IDLE) && !aw_got_q && bus.awvalid;
  assign w_hs  = (wstate_q == W_IDLE) && !w_got_q && bus.wvalid;

  // Commit in the same cycle as the later handshake, so current-cycle values bypass the latches.
  assign commit    = (aw_got_q || aw_hs) && (w_got_q || (w_hs && bus.wlast));
  assign eff_legal = aw_got_q ? aw_legal_q : aw_legal_now;
  assign eff_hi    = aw_got_q ? aw_hi_q : (bus.awaddr == BASE_ADDR + 32'd4);
  assign eff_id    = aw_got_q ? aw_id_q : bus.awid;
  assign eff_wdata = w_got_q ? wdata_q : bus.wdata;
  assign eff_wstrb = w_got_q ? wstrb_q : bus.wstrb;

  always_comb begin
    presc_d = inc ? '0 : presc_q + 1'b1;
    mtime_d = inc ? mtime_q + 64'd1 : mtime_q;
    word    = eff_hi ? mtime_q[63:32] : mtime_q[31:0];
    if (commit && eff_legal) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (eff_wstrb[b]) word[8*b +: 8] = eff_wdata[8*b +: 8];
      end
      mtime_d = eff_hi ? {word, mtime_q[31:0]} : {mtime_q[63:32], word};
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    rlast_d  = rlast_q;
    beats_d  = beats_q;
    snap_d   = snap_q;
    case (rstate_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rid_d    = bus.arid;
          if (ar_legal) begin
            rresp_d = 2'b00;
            rlast_d = 1'b1;
            beats_d = '0;
            if (bus.araddr == BASE_ADDR + 32'd4) begin
              rdata_d = snap_q[63:32];
            end else begin
              rdata_d = mtime_q[31:0];
              snap_d  = mtime_q;
            end
          end else begin
            rdata_d = '0;
            rresp_d = 2'b10;
            beats_d = bus.arlen;
            rlast_d = (bus.arlen == 8'd0);
          end
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          if (rlast_q) begin
            rstate_d = R_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            beats_d = beats_q - 8'd1;
            rlast_d = (beats_q == 8'd1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d   = wstate_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_legal_d = aw_legal_q;
    aw_hi_d    = aw_hi_q;
    aw_id_d    = aw_id_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    case (wstate_q)
      W_IDLE: begin
        if (commit) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = eff_legal ? 2'b00 : 2'b10;
          bid_d    = eff_id;
          wstate_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_got_d   = 1'b1;
            aw_legal_d = aw_legal_now;
            aw_hi_d    = (bus.awaddr == BASE_ADDR + 32'd4);
            aw_id_d    = bus.awid;
          end
          if (w_hs && bus.wlast) begin
            w_got_d = 1'b1;
            wdata_d = bus.wdata;
            wstrb_d = bus.wstrb;
          end
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      snap_q     <= '0;
      rstate_q   <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rid_q      <= '0;
      rlast_q    <= 1'b0;
      beats_q    <= '0;
      wstate_q   <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_legal_q <= 1'b0;
      aw_hi_q    <= 1'b0;
      aw_id_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      snap_q     <= snap_d;
      rstate_q   <= rstate_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rid_q      <= rid_d;
      rlast_q    <= rlast_d;
      beats_q    <= beats_d;
      wstate_q   <= wstate_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_legal_q <= aw_legal_d;
      aw_hi_q    <= aw_hi_d;
      aw_id_q    <= aw_id_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
    end
  end

  assign bus.arready = (rstate_q == R_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = rid_q;
  assign bus.rlast   = rlast_q;
  assign bus.awready = (wstate_q == W_IDLE) && !aw_got_q;
  assign bus.wready  = (wstate_q == W_IDLE) && !w_got_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;
endmodule

// File: tb/tb_axi_clint_responder.sv
// Directed bench for axi_clint_responder; mtime is modelled as a base value plus elapsed clock edges.
module tb_axi_clint_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_clint_if bus();

  axi_clint_responder #(.BASE_ADDR(BASE), .DIV(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Edges seen out of reset; with DIV=1 mtime advances on exactly these edges.
  logic [63:0] tick;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick <= '0;
    else        tick <= tick + 64'd1;
  end

  logic [63:0] base_val  = '0;
  logic [63:0] base_tick = '0;
  logic [63:0] snap_m    = '0;

  function automatic logic [63:0] mt(input logic [63:0] t);
    return base_val + (t - base_tick);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          output logic [63:0] t);
    int n;
    bus.araddr  = addr;
    bus.arid    = id;
    bus.arlen   = len;
    bus.arsize  = 3'b010;
    bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ar_ready", bus.arready, 1);
    t = tick;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic read_beats(input string tag, input int nbeats, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input logic [3:0] exp_id);
    for (int i = 0; i < nbeats; i++) begin
      check({tag, "_rvalid"}, bus.rvalid, 1);
      check({tag, "_rdata"}, bus.rdata, exp_data);
      check({tag, "_rresp"}, bus.rresp, exp_resp);
      check({tag, "_rid"}, bus.rid, exp_id);
      check({tag, "_rlast"}, bus.rlast, (i == nbeats - 1) ? 1 : 0);
      bus.rready = 1'b1;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    check({tag, "_rvalid_end"}, bus.rvalid, 0);
    check({tag, "_arready_end"}, bus.arready, 1);
  endtask

  task automatic read_lo(input string tag, input logic [3:0] id);
    logic [63:0] t, v;
    ar_issue(BASE, id, 8'd0, t);
    v = mt(t);
    snap_m = v;
    read_beats(tag, 1, v[31:0], 2'b00, id);
  endtask

  task automatic read_hi(input string tag, input logic [3:0] id);
    logic [63:0] t;
    ar_issue(BASE + 32'd4, id, 8'd0, t);
    read_beats(tag, 1, snap_m[63:32], 2'b00, id);
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id, input int aw_delay,
                           input logic [1:0] exp_resp);
    bit aw_done, w_done, ah, wh;
    int n;
    logic [63:0] pre;
    logic [31:0] word;
    aw_done = 0; w_done = 0; n = 0; pre = '0;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wlast   = 1'b1;
    bus.wvalid  = 1'b1;
    bus.awaddr  = addr;
    bus.awid    = id;
    bus.awlen   = 8'd0;
    bus.awsize  = 3'b010;
    bus.awburst = 2'b01;
    bus.awvalid = (aw_delay == 0);
    while (!(aw_done && w_done) && n < 50) begin
      ah  = bus.awvalid && bus.awready;
      wh  = bus.wvalid && bus.wready;
      pre = mt(tick);
      @(posedge clk); #1; n++;
      if (ah) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (wh) begin bus.wvalid = 1'b0; w_done = 1; end
      if (!aw_done && !bus.awvalid && n >= aw_delay) bus.awvalid = 1'b1;
      if (!(aw_done && w_done)) check({tag, "_early_b"}, bus.bvalid, 0);
    end
    check({tag, "_done"}, aw_done && w_done, 1);
    check({tag, "_bvalid"}, bus.bvalid, 1);
    check({tag, "_bresp"}, bus.bresp, exp_resp);
    check({tag, "_bid"}, bus.bid, id);
    if (exp_resp == 2'b00) begin
      word = addr[2] ? pre[63:32] : pre[31:0];
      for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
      base_val  = addr[2] ? {word, pre[31:0]} : {pre[63:32], word};
      base_tick = tick;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check({tag, "_bvalid_end"}, bus.bvalid, 0);
    check({tag, "_ready_end"}, {bus.awready, bus.wready}, 2'b11);
  endtask

  initial begin
    logic [63:0] t;
    bus.arvalid = 0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.rready  = 0;
    bus.awvalid = 0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid  = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
    bus.bready  = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", bus.arready, 1);
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rid", bus.rid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_bid", bus.bid, 0);
    rst_n = 1'b1;

    // Stale snapshot before any low-word read is the reset value.
    read_hi("stale_hi", 4'h2);
    repeat (10) @(posedge clk);
    #1;
    read_lo("idle_lo", 4'h5);

    axi_write("wr_hi1", BASE + 32'd4, 32'h0000_0001, 4'hF, 4'h7, 0, 2'b00);
    read_lo("hi1_lo", 4'h1);
    read_hi("hi1_hi", 4'h1);
    check("hi1_word", snap_m[63:32], 64'h1);

    axi_write("wr_hi0", BASE + 32'd4, 32'h0000_0000, 4'hF, 4'h8, 0, 2'b00);
    axi_write("wr_lo_ff", BASE, 32'hFFFF_FFFF, 4'hF, 4'h9, 0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    read_lo("carry_lo", 4'hA);
    read_hi("carry_hi", 4'hA);
    check("carry_word", snap_m[63:32], 64'h1);

    axi_write("wr_strb", BASE, 32'h1234_56AB, 4'b0001, 4'h3, 0, 2'b00);
    read_lo("strb_lo", 4'h4);

    ar_issue(BASE, 4'h3, 8'd3, t);
    for (int i = 0; i < 3; i++) begin
      check("burst_hold_rvalid", bus.rvalid, 1);
      check("burst_hold_rdata", bus.rdata, 0);
      check("burst_hold_rresp", bus.rresp, 2'b10);
      check("burst_hold_rlast", bus.rlast, 0);
      check("burst_hold_rid", bus.rid, 4'h3);
      @(posedge clk); #1;
    end
    read_beats("burst", 4, 32'h0, 2'b10, 4'h3);

    axi_write("wr_bad", BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 4'hC, 2, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    check("bad_single_b", bus.bvalid, 0);
    read_lo("bad_lo", 4'h6);
    read_hi("bad_hi", 4'h6);

    // Reset while a read response is pending.
    ar_issue(BASE, 4'hE, 8'd0, t);
    check("pre_rst_rvalid", bus.rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_arready", bus.arready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base_val = '0; base_tick = '0; snap_m = '0;
    check("post_rst_ready", {bus.arready, bus.awready, bus.wready}, 3'b111);
    check("post_rst_bvalid", bus.bvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    read_lo("post_rst_lo", 4'hB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
